// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative 32-step multiply/divide unit,
// and the EX/MEM pipeline register feeding the memory stage.
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

module execute_stage (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [`WORD-1:0]     srcAE,
  input  logic [`WORD-1:0]     srcBE,
  input  logic [3:0]           aluControlE,
  input  logic [`WORD-1:0]     writeDataE,
  input  logic [`WORD-1:0]     pcE,
  input  logic [`REG_SIZE-1:0] writeRegE,
  input  logic                 regWriteE,
  input  logic                 memWriteE,
  input  logic                 mem2regE,
  input  logic                 branchE,
  input  logic                 finishE,
  input  logic                 validE,
  output logic [`WORD-1:0]     writeDataM,
  output logic [`WORD-1:0]     ALUResultM,
  output logic [`WORD-1:0]     pcM,
  output logic [`REG_SIZE-1:0] writeRegM,
  output logic                 regWriteM,
  output logic                 memWriteM,
  output logic                 mem2regM,
  output logic                 branchM,
  output logic                 finishM,
  output logic                 validM,
  output logic                 zeroM,
  output logic                 busyE
);

  localparam int W          = `WORD;
  localparam int MDU_CYCLES = `WORD;
  localparam int CW         = $clog2(MDU_CYCLES);
  localparam logic [CW-1:0] LAST_STEP = CW'(MDU_CYCLES - 1);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,  OP_SLTU = 4'd9,  OP_MUL  = 4'd10, OP_DIVU = 4'd11,
    OP_REMU = 4'd12, OP_R13  = 4'd13, OP_R14  = 4'd14, OP_R15  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} mdu_state_e;

  typedef struct packed {
    logic [W-1:0]         write_data;
    logic [W-1:0]         alu_result;
    logic [W-1:0]         pc;
    logic [`REG_SIZE-1:0] write_reg;
    logic                 reg_write;
    logic                 mem_write;
    logic                 mem2reg;
    logic                 branch;
    logic                 finish;
    logic                 valid;
    logic                 zero;
  } exmem_t;

  alu_op_e    op;
  logic       is_mdu;
  mdu_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  alu_op_e    mop_q, mop_d;
  // acc: product accumulator / partial remainder; opa: multiplicand / quotient; opb: multiplier / divisor
  logic [W-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [W:0]   div_trial;
  logic [W-1:0] mdu_result, alu_result, ex_result;
  logic [4:0]   shamt;
  exmem_t       exmem_q, exmem_d;

  assign op     = alu_op_e'(aluControlE);
  assign is_mdu = (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  assign busyE  = validE && is_mdu && (state_q != S_DONE);
  assign shamt  = srcBE[4:0];

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = srcAE + srcBE;
      OP_SUB:  alu_result = srcAE - srcBE;
      OP_AND:  alu_result = srcAE & srcBE;
      OP_OR:   alu_result = srcAE | srcBE;
      OP_XOR:  alu_result = srcAE ^ srcBE;
      OP_SLL:  alu_result = srcAE << shamt;
      OP_SRL:  alu_result = srcAE >> shamt;
      OP_SRA:  alu_result = $signed(srcAE) >>> shamt;
      OP_SLT:  alu_result = {{(W-1){1'b0}}, $signed(srcAE) < $signed(srcBE)};
      OP_SLTU: alu_result = {{(W-1){1'b0}}, srcAE < srcBE};
      default: alu_result = '0;
    endcase
  end

  assign div_trial  = {acc_q, opa_q[W-1]};
  assign mdu_result = (mop_q == OP_DIVU) ? opa_q : acc_q;
  assign ex_result  = is_mdu ? mdu_result : alu_result;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mop_d   = mop_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    case (state_q)
      S_IDLE: begin
        if (validE && is_mdu) begin
          state_d = S_RUN;
          count_d = '0;
          mop_d   = op;
          acc_d   = '0;
          opa_d   = srcAE;
          opb_d   = srcBE;
        end
      end
      S_RUN: begin
        if (mop_q == OP_MUL) begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else if (div_trial >= {1'b0, opb_q}) begin
          // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
          acc_d = W'(div_trial - {1'b0, opb_q});
          opa_d = {opa_q[W-2:0], 1'b1};
        end else begin
          acc_d = div_trial[W-1:0];
          opa_d = {opa_q[W-2:0], 1'b0};
        end
        if (count_q == LAST_STEP) state_d = S_DONE;
        else                      count_d = count_q + 1'b1;
      end
      S_DONE:  if (en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exmem_d = exmem_q;
    if (en) begin
      if (busyE) begin
        exmem_d = '0;
      end else begin
        exmem_d.write_data = writeDataE;
        exmem_d.alu_result = ex_result;
        exmem_d.pc         = pcE;
        exmem_d.write_reg  = writeRegE;
        exmem_d.reg_write  = regWriteE;
        exmem_d.mem_write  = memWriteE;
        exmem_d.mem2reg    = mem2regE;
        exmem_d.branch     = branchE;
        exmem_d.finish     = finishE;
        exmem_d.valid      = validE;
        exmem_d.zero       = (ex_result == '0);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mop_q   <= OP_ADD;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      exmem_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mop_q   <= mop_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      exmem_q <= exmem_d;
    end
  end

  assign writeDataM = exmem_q.write_data;
  assign ALUResultM = exmem_q.alu_result;
  assign pcM        = exmem_q.pc;
  assign writeRegM  = exmem_q.write_reg;
  assign regWriteM  = exmem_q.reg_write;
  assign memWriteM  = exmem_q.mem_write;
  assign mem2regM   = exmem_q.mem2reg;
  assign branchM    = exmem_q.branch;
  assign finishM    = exmem_q.finish;
  assign validM     = exmem_q.valid;
  assign zeroM      = exmem_q.zero;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, multi-cycle
// corner sequences, and randomized ops against an arithmetic reference model.
`ifndef WORD
`define WORD 32
`endif
`ifndef REG_SIZE
`define REG_SIZE 5
`endif

module tb_execute_stage;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 en;
  logic [`WORD-1:0]     srcAE, srcBE, writeDataE, pcE;
  logic [3:0]           aluControlE;
  logic [`REG_SIZE-1:0] writeRegE;
  logic                 regWriteE, memWriteE, mem2regE, branchE, finishE, validE;
  logic [`WORD-1:0]     writeDataM, ALUResultM, pcM;
  logic [`REG_SIZE-1:0] writeRegM;
  logic                 regWriteM, memWriteM, mem2regM, branchM, finishM, validM, zeroM;
  logic                 busyE;

  int checks = 0;
  int errors = 0;

  execute_stage dut (
    .clk(clk), .reset(reset), .en(en),
    .srcAE(srcAE), .srcBE(srcBE), .aluControlE(aluControlE),
    .writeDataE(writeDataE), .pcE(pcE), .writeRegE(writeRegE),
    .regWriteE(regWriteE), .memWriteE(memWriteE), .mem2regE(mem2regE),
    .branchE(branchE), .finishE(finishE), .validE(validE),
    .writeDataM(writeDataM), .ALUResultM(ALUResultM), .pcM(pcM),
    .writeRegM(writeRegM), .regWriteM(regWriteM), .memWriteM(memWriteM),
    .mem2regM(mem2regM), .branchM(branchM), .finishM(finishM),
    .validM(validM), .zeroM(zeroM), .busyE(busyE)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] prod;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << b[4:0];
      4'd6:  return a >> b[4:0];
      4'd7:  return $signed(a) >>> b[4:0];
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: begin prod = {32'd0, a} * {32'd0, b}; return prod[31:0]; end
      4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd12: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // Present an instruction with randomized side-band fields.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    aluControlE = op;
    srcAE       = a;
    srcBE       = b;
    writeDataE  = $urandom;
    pcE         = $urandom & 32'hFFFF_FFFC;
    writeRegE   = 5'($urandom_range(0, 31));
    regWriteE   = 1'($urandom_range(0, 1));
    memWriteE   = 1'($urandom_range(0, 1));
    mem2regE    = 1'($urandom_range(0, 1));
    branchE     = 1'($urandom_range(0, 1));
    finishE     = 1'($urandom_range(0, 1));
    validE      = 1'b1;
  endtask

  task automatic check_passthrough(input string name);
    check({name, " writeData"}, writeDataM, writeDataE);
    check({name, " pc"}, pcM, pcE);
    check({name, " writeReg"}, 32'(writeRegM), 32'(writeRegE));
    check({name, " ctrl"}, {26'd0, regWriteM, memWriteM, mem2regM, branchM, finishM, validM},
          {26'd0, regWriteE, memWriteE, mem2regE, branchE, finishE, 1'b1});
  endtask

  task automatic do_single(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    drive(op, a, b);
    en = 1'b1;
    step();
    check(name, ALUResultM, exp);
    check({name, " zero"}, 32'(zeroM), (exp == 0) ? 32'd1 : 32'd0);
    check_passthrough(name);
  endtask

  task automatic run_mdu(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    int edges = 0;
    int busy_cycles = 0;
    drive(op, a, b);
    en = 1'b1;
    #1;
    while (edges < 40) begin
      if (busyE) busy_cycles++;
      step();
      edges++;
      if (validM) break;
    end
    check({name, " busy cycles"}, busy_cycles, 33);
    check({name, " latency"}, edges, 34);
    check(name, ALUResultM, exp);
    check_passthrough(name);
    validE = 1'b0;
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b0;
    en = 1'b0;
    drive(4'd0, 32'd0, 32'd0);
    validE = 1'b0;
    #12;
    check("reset validM", 32'(validM), 32'd0);
    check("reset ALUResultM", ALUResultM, 32'd0);
    check("reset busyE", 32'(busyE), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    vecs.push_back('{"ADD 5+7",       4'd0,  32'd5,          32'd7,         32'd12});
    vecs.push_back('{"SUB 3-3",       4'd1,  32'd3,          32'd3,         32'd0});
    vecs.push_back('{"SRA",           4'd7,  32'h8000_0000,  32'd4,         32'hF800_0000});
    vecs.push_back('{"SLT -1<1",      4'd8,  32'hFFFF_FFFF,  32'd1,         32'd1});
    vecs.push_back('{"SLTU",          4'd9,  32'hFFFF_FFFF,  32'd1,         32'd0});
    vecs.push_back('{"ADD wrap",      4'd0,  32'hFFFF_FFFF,  32'd1,         32'd0});
    vecs.push_back('{"AND",           4'd2,  32'hF0F0_FF00,  32'h0FF0_F0F0, 32'h00F0_F000});
    vecs.push_back('{"OR",            4'd3,  32'hF000_000F,  32'h0F00_00F0, 32'hFF00_00FF});
    vecs.push_back('{"XOR",           4'd4,  32'hAAAA_5555,  32'hFFFF_0000, 32'h5555_5555});
    vecs.push_back('{"SLL 31",        4'd5,  32'd1,          32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{"SRL 31",        4'd6,  32'h8000_0000,  32'd31,        32'd1});
    vecs.push_back('{"op13",          4'd13, 32'd9,          32'd9,         32'd0});
    vecs.push_back('{"op15",          4'd15, 32'hFFFF_FFFF,  32'd1,         32'd0});
    vecs.push_back('{"MUL",           4'd10, 32'h0001_0001,  32'h0001_0001, 32'h0002_0001});
    vecs.push_back('{"DIVU 100/7",    4'd11, 32'd100,        32'd7,         32'd14});
    vecs.push_back('{"REMU 100/7",    4'd12, 32'd100,        32'd7,         32'd2});
    vecs.push_back('{"DIVU x/0",      4'd11, 32'h1234,       32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"REMU x/0",      4'd12, 32'h1234,       32'd0,         32'h1234});

    foreach (vecs[i]) begin
      if (vecs[i].op inside {4'd10, 4'd11, 4'd12})
        run_mdu(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      else
        do_single(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Store pass-through.
    drive(4'd0, 32'h100, 32'h4);
    writeDataE = 32'hDEAD_BEEF;
    memWriteE  = 1'b1;
    pcE        = 32'h40;
    step();
    check("store writeDataM", writeDataM, 32'hDEAD_BEEF);
    check("store memWriteM", 32'(memWriteM), 32'd1);
    check("store pcM", pcM, 32'h40);
    check("store addr", ALUResultM, 32'h104);

    // Stall in DONE: en low for 5 cycles holds the bubble and the FSM.
    begin
      int edges = 0;
      drive(4'd10, 32'd1234, 32'd5678);
      en = 1'b1;
      #1;
      while (busyE && edges < 40) begin
        step();
        edges++;
      end
      check("stall reach DONE edges", edges, 33);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
        step();
        check("stall validM held", 32'(validM), 32'd0);
        check("stall busyE in DONE", 32'(busyE), 32'd0);
      end
      en = 1'b1;
      step();
      check("stall result", ALUResultM, ref_result(4'd10, 32'd1234, 32'd5678));
      check("stall validM", 32'(validM), 32'd1);
      check("stall back to IDLE", 32'(busyE), 32'd1);
      validE = 1'b0;
    end

    // Asynchronous reset mid-RUN abandons the operation.
    drive(4'd11, 32'hFFFF_0000, 32'd3);
    en = 1'b1;
    for (int k = 0; k < 10; k++) step();
    #2;
    reset = 1'b0;
    #1;
    check("rst validM", 32'(validM), 32'd0);
    check("rst ALUResultM", ALUResultM, 32'd0);
    check("rst pcM", pcM, 32'd0);
    check("rst busyE IDLE w/ valid op", 32'(busyE), 32'd1);
    validE = 1'b0;
    #1;
    check("rst busyE invalid", 32'(busyE), 32'd0);
    step();
    check("rst held validM", 32'(validM), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    do_single("post-reset ADD", 4'd0, 32'd5, 32'd7, 32'd12);
    check("post-reset zeroM", 32'(zeroM), 32'd0);

    // Randomized ops against the reference model.
    for (int n = 0; n < 120; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (op inside {4'd11, 4'd12} && $urandom_range(0, 1) == 1) b = b >> $urandom_range(0, 31);
      if (op inside {4'd10, 4'd11, 4'd12})
        run_mdu("rand mdu", op, a, b, ref_result(op, a, b));
      else
        do_single("rand alu", op, a, b, ref_result(op, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
